// File: rtl/storage_arb_mem.sv
// Multi-reader, single-writer row store with arbitrated, registered read port.
// Byte-masked writes bypass into a same-address read on the same edge.
module storage_arb_mem #(
   parameter int ADDR_WIDTH = 10,
   parameter int ROW_WIDTH  = 32,
   parameter int AMT_READER = 4,
   parameter int ARB_MODE   = 0,
   parameter int CNT_WIDTH  = 16,
   localparam int GW = (AMT_READER > 1) ? $clog2(AMT_READER) : 1,
   localparam int NB = ROW_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_WIDTH*AMT_READER-1:0] readAddrs,
   input  logic [AMT_READER-1:0]            readEns,
   input  logic [ADDR_WIDTH-1:0]            writeAddr,
   input  logic [ROW_WIDTH-1:0]             writeData,
   input  logic [NB-1:0]                    writeMask,
   input  logic                             writeEn,
   output logic [AMT_READER-1:0]            readfin,
   output logic [ROW_WIDTH-1:0]             poolReadData,
   output logic [GW-1:0]                    readGrantId,
   output logic [CNT_WIDTH-1:0]             contentionCnt
);

   logic [ROW_WIDTH-1:0]  mem [2**ADDR_WIDTH];
   logic [AMT_READER-1:0] elig;
   logic [GW-1:0]         ptr;
   logic [GW-1:0]         gnt;
   logic                  gnt_vld;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [ROW_WIDTH-1:0]  rrow;
   logic                  hit;
   logic                  multi;

   // a reader whose completion is on the bus must not be served again
   assign elig  = readEns & ~readfin;
   assign multi = |(elig & (elig - 1'b1));

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int k = 0; k < AMT_READER; k++) begin
         if (ARB_MODE == 0) begin
            idx = k;
         end else begin
            idx = int'(ptr) + 1 + k;
            if (idx >= AMT_READER)
               idx = idx - AMT_READER;
         end
         if (!gnt_vld && |(elig & (AMT_READER'(1) << idx))) begin
            gnt_vld = 1'b1;
            gnt     = GW'(idx);
         end
      end
   end

   assign raddr = ADDR_WIDTH'(readAddrs >> (int'(gnt) * ADDR_WIDTH));
   assign hit   = writeEn && (writeAddr == raddr);

   always_comb begin
      rrow = mem[raddr];
      for (int b = 0; b < NB; b++) begin
         if (hit && writeMask[b])
            rrow[8*b +: 8] = writeData[8*b +: 8];
      end
   end

   // storage itself is never cleared; writes only land outside reset
   always_ff @(posedge clk) begin
      if (rst && writeEn) begin
         for (int b = 0; b < NB; b++) begin
            if (writeMask[b])
               mem[writeAddr][8*b +: 8] <= writeData[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         readfin       <= '0;
         poolReadData  <= '0;
         readGrantId   <= '0;
         contentionCnt <= '0;
         ptr           <= GW'(AMT_READER - 1);
      end else begin
         if (gnt_vld) begin
            readfin      <= AMT_READER'(1) << gnt;
            poolReadData <= rrow;
            readGrantId  <= gnt;
            ptr          <= gnt;
         end else begin
            readfin <= '0;
         end
         if (multi && (contentionCnt != '1))
            contentionCnt <= contentionCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_storage_arb_mem.sv
// Bench for storage_arb_mem: fixed-priority and round-robin instances
// checked every cycle against a behavioural model plus directed literals.
module tb_storage_arb_mem;

   localparam int AW = 10;
   localparam int N  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [AW*N-1:0] ra [2];
   logic [N-1:0]    re [2];
   logic [AW-1:0]   wa [2];
   logic [31:0]     wd [2];
   logic [3:0]      wm [2];
   logic            we [2];
   logic [N-1:0]    fin [2];
   logic [31:0]     pdata [2];
   logic [1:0]      gid [2];
   logic [15:0]     cnt0;
   logic [1:0]      cnt1;

   storage_arb_mem #(.ARB_MODE(0), .CNT_WIDTH(16)) dut_fp (
      .clk(clk), .rst(rst),
      .readAddrs(ra[0]), .readEns(re[0]),
      .writeAddr(wa[0]), .writeData(wd[0]),
      .writeMask(wm[0]), .writeEn(we[0]),
      .readfin(fin[0]), .poolReadData(pdata[0]),
      .readGrantId(gid[0]), .contentionCnt(cnt0)
   );

   storage_arb_mem #(.ARB_MODE(1), .CNT_WIDTH(2)) dut_rr (
      .clk(clk), .rst(rst),
      .readAddrs(ra[1]), .readEns(re[1]),
      .writeAddr(wa[1]), .writeData(wd[1]),
      .writeMask(wm[1]), .writeEn(we[1]),
      .readfin(fin[1]), .poolReadData(pdata[1]),
      .readGrantId(gid[1]), .contentionCnt(cnt1)
   );

   int nchk = 0;
   int nerr = 0;

   function automatic void chk(input string nm,
                               input logic [63:0] act,
                               input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // behavioural model
   logic [31:0] mm [2][1024];
   logic [N-1:0] efin [2];
   logic [31:0]  edata [2];
   logic [1:0]   eid [2];
   int           ecnt [2];
   int           eptr [2];
   logic [N-1:0] m_el;
   int           m_g, m_c, m_max;
   logic [AW-1:0] m_a;
   logic [31:0]  m_row;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            efin[d] = '0; edata[d] = '0; eid[d] = '0;
            ecnt[d] = 0;  eptr[d] = N - 1;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_el = re[d] & ~efin[d];
            m_g  = -1;
            for (int k = 0; k < N; k++) begin
               m_c = (d == 0) ? k : (eptr[d] + 1 + k) % N;
               if (m_g < 0 && m_el[m_c]) m_g = m_c;
            end
            m_row = '0;
            if (m_g >= 0) begin
               m_a   = ra[d][m_g*AW +: AW];
               m_row = mm[d][m_a];
               if (we[d] && wa[d] == m_a)
                  for (int b = 0; b < 4; b++)
                     if (wm[d][b]) m_row[8*b +: 8] = wd[d][8*b +: 8];
            end
            if (we[d])
               for (int b = 0; b < 4; b++)
                  if (wm[d][b]) mm[d][wa[d]][8*b +: 8] = wd[d][8*b +: 8];
            m_max = (d == 0) ? 65535 : 3;
            if ($countones(m_el) >= 2 && ecnt[d] < m_max)
               ecnt[d] = ecnt[d] + 1;
            if (m_g >= 0) begin
               efin[d]  = N'(1) << m_g;
               edata[d] = m_row;
               eid[d]   = 2'(m_g);
               eptr[d]  = m_g;
            end else begin
               efin[d] = '0;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("fin%0d", d), 64'(fin[d]), 64'(efin[d]));
         chk($sformatf("data%0d", d), 64'(pdata[d]), 64'(edata[d]));
         chk($sformatf("gid%0d", d), 64'(gid[d]), 64'(eid[d]));
      end
      chk("cnt0", 64'(cnt0), 64'(ecnt[0]));
      chk("cnt1", 64'(cnt1), 64'(ecnt[1]));
   end

   int          gq [$];
   int          cq [$];
   logic [31:0] dq [$];
   logic [N-1:0] fq [$];

   task automatic wr(input int d, input int a, input logic [31:0] v,
                     input logic [3:0] m);
      wa[d] = AW'(a); wd[d] = v; wm[d] = m; we[d] = 1'b1;
      @(negedge clk);
      we[d] = 1'b0;
   endtask

   task automatic run_reqs(input int d, input logic [N-1:0] m,
                           input int budget, input bit cont);
      gq.delete(); cq.delete(); dq.delete(); fq.delete();
      re[d] = re[d] | m;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (fin[d] != '0) begin
            gq.push_back(int'(gid[d]));
            dq.push_back(pdata[d]);
            fq.push_back(fin[d]);
            cq.push_back(n);
            if (!cont) re[d] = re[d] & ~fin[d];
         end
         if (!cont && re[d] == '0) break;
      end
      if (cont) re[d] = '0;
      else chk("serve_timeout", 64'(re[d]), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         ra[d] = '0; re[d] = '0; wa[d] = '0;
         wd[d] = '0; wm[d] = '0; we[d] = 1'b0;
      end
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_fin", 64'(fin[1]), 64'd0);
      chk("rst_data", 64'(pdata[0]), 64'd0);
      chk("rst_gid", 64'(gid[1]), 64'd0);
      chk("rst_cnt", 64'(cnt0), 64'd0);
      rst = 1'b1;

      // single read after write
      wr(0, 5, 32'hDEADBEEF, 4'hF);
      ra[0][1*AW +: AW] = AW'(5);
      run_reqs(0, 4'b0010, 6, 1'b0);
      chk("t1_n", 64'(gq.size()), 64'd1);
      chk("t1_fin", 64'(fq[0]), 64'b0010);
      chk("t1_id", 64'(gq[0]), 64'd1);
      chk("t1_data", 64'(dq[0]), 64'hDEADBEEF);

      // fixed priority, three contenders
      wr(0, 1, 32'h101, 4'hF);
      wr(0, 2, 32'h202, 4'hF);
      wr(0, 3, 32'h303, 4'hF);
      ra[0][0*AW +: AW] = AW'(1);
      ra[0][2*AW +: AW] = AW'(2);
      ra[0][3*AW +: AW] = AW'(3);
      run_reqs(0, 4'b1101, 8, 1'b0);
      chk("t2_n", 64'(gq.size()), 64'd3);
      chk("t2_g0", 64'(gq[0]), 64'd0);
      chk("t2_g1", 64'(gq[1]), 64'd2);
      chk("t2_g2", 64'(gq[2]), 64'd3);
      chk("t2_d2", 64'(dq[2]), 64'h303);
      chk("t2_back", 64'(cq[2] - cq[0]), 64'd2);
      chk("t2_cnt", 64'(cnt0), 64'd2);

      // round robin, all readers held
      for (int i = 0; i < N; i++) begin
         wr(1, 10 + i, 32'hA0 + 32'(i), 4'hF);
         ra[1][i*AW +: AW] = AW'(10 + i);
      end
      run_reqs(1, 4'b1111, 8, 1'b1);
      chk("t3_n", 64'(gq.size()), 64'd8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t3_g%0d", k), 64'(gq[k]), 64'(k % N));
      chk("t3_cnt", 64'(cnt1), 64'd3);

      // masked write bypassing a same-edge read
      wr(0, 7, 32'h11223344, 4'hF);
      ra[0][0*AW +: AW] = AW'(7);
      re[0] = 4'b0001;
      wa[0] = AW'(7); wd[0] = 32'hAABBCCDD;
      wm[0] = 4'b0101; we[0] = 1'b1;
      @(negedge clk);
      we[0] = 1'b0; re[0] = '0;
      chk("t4_fin", 64'(fin[0]), 64'b0001);
      chk("t4_data", 64'(pdata[0]), 64'h11BB33DD);
      ra[0][2*AW +: AW] = AW'(7);
      run_reqs(0, 4'b0100, 6, 1'b0);
      chk("t4_reread", 64'(dq[0]), 64'h11BB33DD);

      // async reset mid-stream
      re[1] = 4'b0100;
      @(negedge clk);
      chk("t5_pre", 64'(fin[1]), 64'b0100);
      #2 rst = 1'b0;
      #1;
      chk("t5_fin", 64'(fin[1]), 64'd0);
      chk("t5_data", 64'(pdata[1]), 64'd0);
      chk("t5_gid", 64'(gid[1]), 64'd0);
      chk("t5_cnt0", 64'(cnt0), 64'd0);
      chk("t5_cnt1", 64'(cnt1), 64'd0);
      wa[0] = AW'(5); wd[0] = 32'h0; wm[0] = 4'hF; we[0] = 1'b1;
      re[1] = 4'b1111;
      @(negedge clk);
      we[0] = 1'b0;
      #2 rst = 1'b1;

      // first grant after reset, then saturation
      run_reqs(1, 4'b1111, 6, 1'b1);
      chk("t6_first", 64'(gq[0]), 64'd0);
      chk("t6_keep", 64'(dq[0]), 64'hA0);
      chk("t6_sat", 64'(cnt1), 64'd3);
      run_reqs(0, 4'b0010, 6, 1'b0);
      chk("t6_nowr", 64'(dq[0]), 64'hDEADBEEF);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
